// File: rtl/interlock_seq_card_pkg.sv
// card_pkg: shared state type, widths and state-decode helpers for the
// interlock card family.
//   seq_state_t : sequencer state (IDLE, STANDBY, RAMP, HV_ON, FAULT)
//   sb_active() : standby supply should be on in this state
//   hv_active() : HV enable should be driven in this state
package card_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    STANDBY = 3'd1,
    RAMP    = 3'd2,
    HV_ON   = 3'd3,
    FAULT   = 3'd4
  } seq_state_t;

  function automatic logic sb_active(input seq_state_t s);
    return (s == STANDBY) || (s == RAMP) || (s == HV_ON);
  endfunction

  function automatic logic hv_active(input seq_state_t s);
    return (s == RAMP) || (s == HV_ON);
  endfunction

endpackage

// File: rtl/interlock_seq_card_debounce.sv
// permit_debounce: single-bit debounce filter for one active-low permit.
// The filtered value flips only after the raw input has disagreed with it on
// DEBOUNCE_CYC consecutive clock edges; any agreeing edge restarts the count.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous, active-high; filtered resets to 1 (not permitted)
//   raw      in  raw permit input
//   filtered out debounced permit
module permit_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int unsigned     CW   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (raw == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      // this edge is the DEBOUNCE_CYC-th consecutive disagreement
      filt_d = raw;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filtered = filt_q;

endmodule

// File: rtl/interlock_seq_card.sv
// interlock_seq_card: debounces N_PERMIT active-low permits and sequences the
// RF supply through standby -> HV ramp -> HV on, latching the cause of any trip
// until an operator fault clear with all permits good.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_permit_b          raw permits (0 = OK)
//   i_g2_on, i_anode_on HV request (both required)
//   i_rf_perm           upstream RF permit
//   i_an_hv_ready       anode supply at level
//   i_fault_clr         operator fault clear (level)
//   o_sb_on_b/o_sb_off_b  standby drive, active-low / complement
//   o_hv_on/o_hv_on_b     HV enable / complement
//   o_hv_ready          HV at level and permitted
//   o_fault_mask        sticky record of permits bad around a trip
//   o_ramp_timeout      sticky: trip caused by ramp timeout
//   o_state             state encoding for diagnostics
module interlock_seq_card
  import card_pkg::*;
#(
  parameter int unsigned N_PERMIT     = 3,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned RAMP_CYC     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_PERMIT-1:0] i_permit_b,
  input  logic                i_g2_on,
  input  logic                i_anode_on,
  input  logic                i_rf_perm,
  input  logic                i_an_hv_ready,
  input  logic                i_fault_clr,
  output logic                o_sb_on_b,
  output logic                o_sb_off_b,
  output logic                o_hv_on,
  output logic                o_hv_on_b,
  output logic                o_hv_ready,
  output logic [N_PERMIT-1:0] o_fault_mask,
  output logic                o_ramp_timeout,
  output logic [STATE_W-1:0]  o_state
);

  localparam int unsigned    RCW       = $clog2(RAMP_CYC) + 1;
  localparam logic [RCW-1:0] RAMP_LAST = RCW'(RAMP_CYC - 1);

  logic [N_PERMIT-1:0] filt;
  seq_state_t          state_q, state_d;
  logic [RCW-1:0]      ramp_cnt_q, ramp_cnt_d;
  logic [N_PERMIT-1:0] mask_q, mask_d;
  logic                tmo_q, tmo_d;
  logic                ok, req, clr_ok;

  for (genvar g = 0; g < N_PERMIT; g++) begin : g_deb
    permit_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .raw      (i_permit_b[g]),
      .filtered (filt[g])
    );
  end

  assign ok     = (filt == '0);
  assign req    = i_g2_on & i_anode_on;
  assign clr_ok = (state_q == FAULT) & i_fault_clr & ok;

  always_comb begin
    state_d    = state_q;
    ramp_cnt_d = ramp_cnt_q;
    mask_d     = mask_q;
    tmo_d      = tmo_q;

    // counter only advances in RAMP and saturates at the decision point
    if ((state_q == RAMP) && (ramp_cnt_q != RAMP_LAST)) begin
      ramp_cnt_d = ramp_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ok) state_d = STANDBY;
      end
      STANDBY: begin
        if (!ok) begin
          state_d = FAULT;
        end else if (req && i_rf_perm) begin
          state_d    = RAMP;
          ramp_cnt_d = '0;
        end
      end
      RAMP: begin
        if (!ok || !i_rf_perm) begin
          state_d = FAULT;
        end else if (!req) begin
          state_d = STANDBY;
        end else if (ramp_cnt_q == RAMP_LAST) begin
          if (i_an_hv_ready) begin
            state_d = HV_ON;
          end else begin
            state_d = FAULT;
            tmo_d   = 1'b1;
          end
        end
      end
      HV_ON: begin
        if (!ok || !i_rf_perm || !i_an_hv_ready) begin
          state_d = FAULT;
        end else if (!req) begin
          state_d = STANDBY;
        end
      end
      FAULT: begin
        if (i_fault_clr && ok) state_d = IDLE;
      end
      default: state_d = FAULT;
    endcase

    // a successful clear wins over accumulation (filt is all-zero then anyway)
    if (clr_ok) begin
      mask_d = '0;
      tmo_d  = 1'b0;
    end else if ((state_d == FAULT) || (state_q == FAULT)) begin
      mask_d = mask_q | filt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ramp_cnt_q <= '0;
      mask_q     <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ramp_cnt_q <= ramp_cnt_d;
      mask_q     <= mask_d;
      tmo_q      <= tmo_d;
    end
  end

  // Moore decodes straight off the state register so reset drops HV immediately
  assign o_sb_on_b      = ~sb_active(state_q);
  assign o_sb_off_b     = sb_active(state_q);
  assign o_hv_on        = hv_active(state_q);
  assign o_hv_on_b      = ~hv_active(state_q);
  assign o_hv_ready     = (state_q == HV_ON);
  assign o_fault_mask   = mask_q;
  assign o_ramp_timeout = tmo_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_interlock_seq_card.sv
module tb_interlock_seq_card;

  localparam int unsigned NP = 3;
  localparam int unsigned DB = 4;
  localparam int unsigned RC = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NP-1:0] i_permit_b = '0;
  logic          i_g2_on = 1'b0, i_anode_on = 1'b0, i_rf_perm = 1'b0;
  logic          i_an_hv_ready = 1'b0, i_fault_clr = 1'b0;
  logic          o_sb_on_b, o_sb_off_b, o_hv_on, o_hv_on_b, o_hv_ready;
  logic [NP-1:0] o_fault_mask;
  logic          o_ramp_timeout;
  logic [2:0]    o_state;

  interlock_seq_card #(
    .N_PERMIT(NP), .DEBOUNCE_CYC(DB), .RAMP_CYC(RC)
  ) dut (
    .clk(clk), .reset(reset), .i_permit_b(i_permit_b), .i_g2_on(i_g2_on),
    .i_anode_on(i_anode_on), .i_rf_perm(i_rf_perm), .i_an_hv_ready(i_an_hv_ready),
    .i_fault_clr(i_fault_clr), .o_sb_on_b(o_sb_on_b), .o_sb_off_b(o_sb_off_b),
    .o_hv_on(o_hv_on), .o_hv_on_b(o_hv_on_b), .o_hv_ready(o_hv_ready),
    .o_fault_mask(o_fault_mask), .o_ramp_timeout(o_ramp_timeout), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]    st;
    logic          sb_on_b, sb_off_b, hv_on, hv_on_b, hv_ready;
    logic [NP-1:0] mask;
    logic          tmo;
  } exp_t;

  exp_t          exp_q[$];
  logic [NP-1:0] m_hist[$];   // most recent raw samples, newest last
  logic [NP-1:0] m_filt;
  int            m_st;        // 0 IDLE 1 STANDBY 2 RAMP 3 HV_ON 4 FAULT
  int            m_elapsed;   // cycles spent ramping
  logic [NP-1:0] m_mask;
  logic          m_tmo;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < int'(DB); i++) m_hist.push_back('1);
    m_filt = '1; m_st = 0; m_elapsed = 0; m_mask = '0; m_tmo = 1'b0;
  endtask

  task automatic model_step(input logic rst, input logic [NP-1:0] raw, input logic g2,
                            input logic an, input logic rf, input logic rdy, input logic clr);
    exp_t e;
    int   nxt;
    bit   ok, req, cleared;
    logic [NP-1:0] newf;
    if (rst) begin
      model_reset();
    end else begin
      ok = (m_filt == '0);
      req = g2 && an;
      nxt = m_st;
      cleared = 0;
      case (m_st)
        0: if (ok) nxt = 1;
        1: if (!ok) nxt = 4; else if (req && rf) begin nxt = 2; m_elapsed = 0; end
        2: if (!ok || !rf) nxt = 4;
           else if (!req) nxt = 1;
           else begin
             m_elapsed++;
             if (m_elapsed >= int'(RC)) begin
               if (rdy) nxt = 3; else begin nxt = 4; m_tmo = 1'b1; end
             end
           end
        3: if (!ok || !rf || !rdy) nxt = 4; else if (!req) nxt = 1;
        default: if (clr && ok) begin nxt = 0; cleared = 1; end
      endcase
      if (nxt == 4 || m_st == 4) m_mask |= m_filt;
      if (cleared) begin m_mask = '0; m_tmo = 1'b0; end
      m_st = nxt;
      // a bit flips once its last DB raw samples all disagree with it
      m_hist.push_back(raw);
      if (m_hist.size() > int'(DB)) void'(m_hist.pop_front());
      newf = m_filt;
      for (int b = 0; b < int'(NP); b++) begin
        bit all_diff = 1;
        foreach (m_hist[k]) if (m_hist[k][b] == m_filt[b]) all_diff = 0;
        if (all_diff) newf[b] = ~m_filt[b];
      end
      m_filt = newf;
    end
    e.st       = 3'(m_st);
    e.sb_on_b  = !(m_st >= 1 && m_st <= 3);
    e.sb_off_b = (m_st >= 1 && m_st <= 3);
    e.hv_on    = (m_st == 2 || m_st == 3);
    e.hv_on_b  = !(m_st == 2 || m_st == 3);
    e.hv_ready = (m_st == 3);
    e.mask     = m_mask;
    e.tmo      = m_tmo;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state",        o_state,        e.st);
      chk("sb_on_b",      o_sb_on_b,      e.sb_on_b);
      chk("sb_off_b",     o_sb_off_b,     e.sb_off_b);
      chk("hv_on",        o_hv_on,        e.hv_on);
      chk("hv_on_b",      o_hv_on_b,      e.hv_on_b);
      chk("hv_ready",     o_hv_ready,     e.hv_ready);
      chk("fault_mask",   o_fault_mask,   e.mask);
      chk("ramp_timeout", o_ramp_timeout, e.tmo);
    end
  end

  // ---------------- stimulus ----------------
  // drive one cycle's inputs (called at a negedge), record expectation, advance
  task automatic step(input logic rst, input logic [NP-1:0] perm, input logic g2,
                      input logic an, input logic rf, input logic rdy, input logic clr);
    reset = rst; i_permit_b = perm; i_g2_on = g2; i_anode_on = an;
    i_rf_perm = rf; i_an_hv_ready = rdy; i_fault_clr = clr;
    model_step(rst, perm, g2, an, rf, rdy, clr);
    @(negedge clk);
  endtask

  logic [NP-1:0] rnd_raw;

  initial begin
    model_reset();
    @(negedge clk);
    repeat (3) step(1, '0, 0, 0, 1, 0, 0);
    chk("reset_state", o_state, 3'd0);
    chk("reset_sb_on_b", o_sb_on_b, 1'b1);

    // 1: filter settles on the 4th edge, STANDBY on the 5th
    repeat (4) step(0, '0, 0, 0, 1, 0, 0);
    chk("t1_still_idle", o_state, 3'd0);
    step(0, '0, 0, 0, 1, 0, 0);
    chk("t1_standby", o_state, 3'd1);

    // 2: ramp; ready is don't-care until the final ramp cycle
    step(0, '0, 1, 1, 1, 1, 0);
    chk("t2_ramp", o_state, 3'd2);
    for (int i = 0; i < int'(RC); i++)
      step(0, '0, 1, 1, 1, (i == int'(RC) - 1) ? 1'b1 : 1'($urandom_range(0, 1)), 0);
    chk("t2_hv_on", o_state, 3'd3);
    chk("t2_hv_ready", o_hv_ready, 1'b1);

    // 3: 3-cycle glitch is filtered, 4-cycle hold trips
    repeat (3) step(0, 3'b010, 1, 1, 1, 1, 0);
    repeat (3) step(0, 3'b000, 1, 1, 1, 1, 0);
    chk("t3_glitch_held", o_state, 3'd3);
    repeat (5) step(0, 3'b010, 1, 1, 1, 1, 0);
    chk("t3_fault", o_state, 3'd4);
    chk("t3_mask", o_fault_mask, 3'b010);

    // 4: clear ignored while permit bad, honoured once filtered good
    repeat (3) step(0, 3'b010, 0, 0, 1, 1, 1);
    chk("t4_clr_ignored", o_state, 3'd4);
    repeat (4) step(0, 3'b000, 0, 0, 1, 1, 0);
    step(0, 3'b000, 0, 0, 1, 1, 1);
    chk("t4_idle", o_state, 3'd0);
    chk("t4_mask_clr", o_fault_mask, 3'b000);
    step(0, 3'b000, 0, 0, 1, 1, 0);
    chk("t4_standby", o_state, 3'd1);

    // 5: ramp timeout
    step(0, '0, 1, 1, 1, 0, 0);
    repeat (RC) step(0, '0, 1, 1, 1, 0, 0);
    chk("t5_fault", o_state, 3'd4);
    chk("t5_timeout", o_ramp_timeout, 1'b1);
    chk("t5_mask", o_fault_mask, 3'b000);
    step(0, '0, 0, 0, 1, 0, 1);
    step(0, '0, 0, 0, 1, 0, 0);

    // 6: asynchronous reset mid-ramp
    step(0, '0, 1, 1, 1, 0, 0);
    repeat (5) step(0, '0, 1, 1, 1, 0, 0);
    chk("t6_in_ramp", o_hv_on, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_hv_off", o_hv_on, 1'b0);
    chk("t6_async_state", o_state, 3'd0);
    chk("t6_async_mask", o_fault_mask, 3'b000);
    exp_q.delete();
    model_reset();
    repeat (2) step(1, '0, 0, 0, 1, 0, 0);

    // random phase: slowly toggling permits with mostly-good controls
    rnd_raw = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < int'(NP); b++)
        if ($urandom_range(0, 15) == 0) rnd_raw[b] = ~rnd_raw[b];
      step(($urandom_range(0, 499) == 0),
           rnd_raw,
           ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 29) != 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 7) == 0));
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
